// File: rtl/lmsm_seq.sv
// Load/store-multiple sequencer: walks a register mask in ascending order, one transfer per cycle.
// Optional macro LMSM_PC_SKIP_EN excludes R7 (PC) from every sequence.
module lmsm_seq #(
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_lm,
  input  logic [7:0]  reg_mask,
  input  logic [15:0] base_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] mem_wr_data,
  output logic [2:0]  rf_rd_addr,
  input  logic [15:0] rf_rd_data,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        rf_wr_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r, state_nx_s;
  logic        is_lm_r, is_lm_nx_s;
  logic [15:0] addr_r, addr_nx_s;
  logic [7:0]  mask_r, mask_nx_s;
  logic [2:0]  idx_r, idx_nx_s;
  logic [7:0]  eff_mask_s;
  logic [7:0]  mask_left_s;
  logic        mem_rd_en_r, mem_wr_en_r, rf_wr_en_r, busy_r, done_r;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] r;
    casez (m)
      8'b???????1: r = 3'd0;
      8'b??????10: r = 3'd1;
      8'b?????100: r = 3'd2;
      8'b????1000: r = 3'd3;
      8'b???10000: r = 3'd4;
      8'b??100000: r = 3'd5;
      8'b?1000000: r = 3'd6;
      8'b10000000: r = 3'd7;
      default:     r = 3'd0;
    endcase
    return r;
  endfunction

`ifdef LMSM_PC_SKIP_EN
  assign eff_mask_s = {1'b0, reg_mask[6:0]};
`else
  assign eff_mask_s = reg_mask;
`endif

  assign mask_left_s = mask_r & ~(8'b0000_0001 << idx_r);

  // Next-state and datapath-next logic; address and index only advance while more registers remain,
  // so they hold the last transferred slot once the sequence ends.
  always_comb begin
    state_nx_s = state_r;
    is_lm_nx_s = is_lm_r;
    addr_nx_s  = addr_r;
    mask_nx_s  = mask_r;
    idx_nx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          is_lm_nx_s = is_lm;
          mask_nx_s  = eff_mask_s;
          if (eff_mask_s != 8'd0) begin
            addr_nx_s  = base_addr;
            idx_nx_s   = lowest_idx(eff_mask_s);
            state_nx_s = XFER;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      XFER: begin
        mask_nx_s = mask_left_s;
        if (mask_left_s != 8'd0) begin
          addr_nx_s  = addr_r + ADDR_STEP;
          idx_nx_s   = lowest_idx(mask_left_s);
          state_nx_s = XFER;
        end else begin
          state_nx_s = DONE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath registers and registered strobes decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_lm_r     <= 1'b0;
      addr_r      <= 16'h0000;
      mask_r      <= 8'h00;
      idx_r       <= 3'd0;
      mem_rd_en_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      rf_wr_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      is_lm_r     <= is_lm_nx_s;
      addr_r      <= addr_nx_s;
      mask_r      <= mask_nx_s;
      idx_r       <= idx_nx_s;
      mem_rd_en_r <= (state_nx_s == XFER) && is_lm_nx_s;
      rf_wr_en_r  <= (state_nx_s == XFER) && is_lm_nx_s;
      mem_wr_en_r <= (state_nx_s == XFER) && !is_lm_nx_s;
      busy_r      <= (state_nx_s == XFER);
      done_r      <= (state_nx_s == DONE);
    end
  end

  assign mem_addr    = addr_r;
  assign rf_rd_addr  = idx_r;
  assign rf_wr_addr  = idx_r;
  assign mem_rd_en   = mem_rd_en_r;
  assign mem_wr_en   = mem_wr_en_r;
  assign rf_wr_en    = rf_wr_en_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_wr_data = rf_rd_data;
  assign rf_wr_data  = mem_rd_data;

endmodule

// File: tb/tb_lmsm_seq.sv
// Scoreboard bench for lmsm_seq: expected transfers are queued at start and matched per cycle.
module tb_lmsm_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_lm;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic [15:0] mem_addr, mem_rd_data, mem_wr_data, rf_rd_data, rf_wr_data;
  logic        mem_rd_en, mem_wr_en, rf_wr_en, busy, done;
  logic [2:0]  rf_rd_addr, rf_wr_addr;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic busy_seen = 1'b0;

  typedef struct {
    int kind;   // 0 = rf write (LM), 1 = mem write (SM), 2 = done
    int cyc;
    int idx;
    int addr;
    int data;
  } ev_t;
  ev_t exp_q[$];
  ev_t e;
  int  kind;

  lmsm_seq #(.ADDR_STEP(16'd1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_lm(is_lm), .reg_mask(reg_mask),
    .base_addr(base_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];
  assign rf_rd_data  = rf[rf_rd_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en === 1'b1) mem[mem_addr] <= mem_wr_data;
    if (rf_wr_en === 1'b1) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (done === 1'b1 || mem_wr_en === 1'b1 || rf_wr_en === 1'b1 || mem_rd_en === 1'b1) begin
      kind = (done === 1'b1) ? 2 : (mem_wr_en === 1'b1) ? 1 : (rf_wr_en === 1'b1) ? 0 : 3;
      check_val("wr_excl", 32'(rf_wr_en & mem_wr_en), 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_event", 32'(kind), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("kind", 32'(kind), 32'(e.kind));
        check_val("cycle", 32'(cyc), 32'(e.cyc));
        check_val("busy", 32'(busy), 32'(e.kind != 2));
        if (e.kind == 0) begin
          check_val("lm_rf_addr", 32'(rf_wr_addr), 32'(e.idx));
          check_val("lm_mem_addr", 32'(mem_addr), 32'(e.addr));
          check_val("lm_data", 32'(rf_wr_data), 32'(e.data));
          check_val("lm_rd_en", 32'(mem_rd_en), 32'd1);
        end else if (e.kind == 1) begin
          check_val("sm_rf_addr", 32'(rf_rd_addr), 32'(e.idx));
          check_val("sm_mem_addr", 32'(mem_addr), 32'(e.addr));
          check_val("sm_data", 32'(mem_wr_data), 32'(e.data));
          check_val("sm_rd_en", 32'(mem_rd_en), 32'd0);
        end else begin
          check_val("done_strobes", 32'({mem_rd_en, mem_wr_en, rf_wr_en}), 32'd0);
        end
      end
    end
  end

  // Push the expected trace for one sequence starting in cycle t.
  task automatic push_expected(input logic lm, input logic [7:0] m, input logic [15:0] b,
                               input int t, input int max_regs, input logic with_done);
    logic [7:0]  eff;
    logic [15:0] a;
    int k;
    eff = m;
`ifdef LMSM_PC_SKIP_EN
    eff[7] = 1'b0;
`endif
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (eff[i] && k < max_regs) begin
        a = b + 16'(k);
        exp_q.push_back('{lm ? 0 : 1, t + 1 + k, i, int'(a), lm ? int'(mem[a]) : int'(rf[i])});
        k++;
      end
    end
    if (with_done) exp_q.push_back('{2, t + 1 + k, 0, 0, 0});
  endtask

  task automatic drain(input int max_wait);
    for (int w = 0; w < max_wait && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    check_val("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_seq(input logic lm, input logic [7:0] m, input logic [15:0] b);
    @(posedge clk); #1;
    start = 1'b1; is_lm = lm; reg_mask = m; base_addr = b;
    push_expected(lm, m, b, cyc, 8, 1'b1);
    @(posedge clk); #1;
    start = 1'b0; is_lm = ~lm; reg_mask = 8'hFF; base_addr = 16'h5A5A;
    drain(20);
  endtask

  task automatic check_idle_outs(input string tag);
    @(negedge clk);
    check_val({tag, "_ctl"}, 32'({busy, done, mem_rd_en, mem_wr_en, rf_wr_en}), 32'd0);
    check_val({tag, "_addr"}, 32'({mem_addr, rf_rd_addr, rf_wr_addr}), 32'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rst = 1'b1; start = 1'b0; is_lm = 1'b0; reg_mask = 8'h00; base_addr = 16'h0000;
    repeat (2) @(posedge clk);
    check_idle_outs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // LM R0,R2 from 0x0100
    mem[16'h0100] = 16'hAAAA; mem[16'h0101] = 16'h5555;
    run_seq(1'b1, 8'h05, 16'h0100);
    check_val("lm_r0", 32'(rf[0]), 32'h0000AAAA);
    check_val("lm_r2", 32'(rf[2]), 32'h00005555);

    // SM R0,R7 to 0x0200; R7 slot depends on the PC-skip build
    rf[0] = 16'h1234; rf[7] = 16'h00FE;
    run_seq(1'b0, 8'h81, 16'h0200);
    check_val("sm_m200", 32'(mem[16'h0200]), 32'h00001234);
`ifdef LMSM_PC_SKIP_EN
    check_val("sm_m201", 32'(mem[16'h0201]), 32'h00000000);
`else
    check_val("sm_m201", 32'(mem[16'h0201]), 32'h000000FE);
`endif

    // Empty mask: done only, never busy
    busy_seen = 1'b0;
    run_seq(1'b1, 8'h00, 16'h0300);
    check_val("empty_busy", 32'(busy_seen), 32'd0);

    // Address wrap
    rf[1] = 16'h1111; rf[2] = 16'h2222;
    run_seq(1'b0, 8'h07, 16'hFFFF);
    check_val("wrap_ffff", 32'(mem[16'hFFFF]), 32'h00001234);
    check_val("wrap_0000", 32'(mem[16'h0000]), 32'h00001111);
    check_val("wrap_0001", 32'(mem[16'h0001]), 32'h00002222);

    // Sparse high mask including R7
    mem[16'h0010] = 16'hC0DE; mem[16'h0011] = 16'hBEEF;
    run_seq(1'b1, 8'hA0, 16'h0010);

    // Abort mid-sequence: re-pulsed start ignored, reset kills the rest
    for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] = 16'h4000 + 16'(i);
    rf[3] = 16'hDEAD;
    @(posedge clk); #1;
    start = 1'b1; is_lm = 1'b1; reg_mask = 8'hFF; base_addr = 16'h0400;
    t = cyc;
    push_expected(1'b1, 8'hFF, 16'h0400, t, 3, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; is_lm = 1'b0; reg_mask = 8'h01; base_addr = 16'h0700;
    @(posedge clk); #1 start = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    drain(1);
    check_idle_outs("abort");
    check_val("abort_r2", 32'(rf[2]), 32'h00004002);
    check_val("abort_r3", 32'(rf[3]), 32'h0000DEAD);

    // Recovery after reset
    rf[1] = 16'h0A0A; rf[4] = 16'h0B0B;
    run_seq(1'b0, 8'h12, 16'h0500);
    check_val("rec_m500", 32'(mem[16'h0500]), 32'h00000A0A);
    check_val("rec_m501", 32'(mem[16'h0501]), 32'h00000B0B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
